// File: rtl/ir_score_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ir_score_pkg
// Shared types, constants and increment helpers for the IR score tracker.
// This package has no ports. It provides:
//   bcd_digit_t    one BCD digit (0..9)
//   bcd_score_t    two-digit BCD score {tens, units}
//   bcd_inc()      BCD score + 1, wrapping 99 -> 00
//   bin_inc()      binary score + 1, wrapping 99 -> 0
// ----------------------------------------------------------------------------
package ir_score_pkg;

    localparam int BCD_MAX_DIGIT = 9;
    localparam int SCORE_MAX     = 99;
    localparam int SCORE_BIN_W   = 7;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t units;
    } bcd_score_t;

    // The units digit wraps to 0 with a carry into tens. Tens also wraps, so 99 becomes 00.
    function automatic bcd_score_t bcd_inc(input bcd_score_t s);
        bcd_score_t r;
        // NOTE: blocking assignments are right here; a function computes a value and holds no state.
        r = s;
        if (s.units == bcd_digit_t'(BCD_MAX_DIGIT)) begin
            r.units = '0;
            r.tens  = (s.tens == bcd_digit_t'(BCD_MAX_DIGIT)) ? '0 : s.tens + 4'd1;
        end else begin
            r.units = s.units + 4'd1;
        end
        return r;
    endfunction

    // Binary shadow of bcd_inc, so score_bin never needs a BCD-to-binary multiply.
    function automatic logic [SCORE_BIN_W-1:0] bin_inc(input logic [SCORE_BIN_W-1:0] b);
        return (b == SCORE_BIN_W'(SCORE_MAX)) ? '0 : b + 7'd1;
    endfunction

endpackage

// File: rtl/ir_score_tracker_if.sv
// ----------------------------------------------------------------------------
// ir_score_tracker_if
// Bundles the sensor, control and score signals of ir_score_tracker.
//   enable     1 = hits are counted
//   clear      synchronous clear for a new game
//   ir_sensor  raw asynchronous beam sensors, one bit per channel
//   hit_pulse  one-cycle pulse for each counted hit
//   score_bcd  per channel {tens, units}; channel 0 is in [7:0]
//   score_bin  per channel binary score; channel 0 is in [6:0]
//   winner     channels that reached the winning score
//   game_over  set when any winner bit is set
// Modports: master is the game controller and sensors. slave is the tracker.
// ----------------------------------------------------------------------------
interface ir_score_tracker_if
    import ir_score_pkg::*;
#(
    parameter int NUM_CH = 2
);
    logic                          enable;
    logic                          clear;
    logic [NUM_CH-1:0]             ir_sensor;
    logic [NUM_CH-1:0]             hit_pulse;
    logic [8*NUM_CH-1:0]           score_bcd;
    logic [SCORE_BIN_W*NUM_CH-1:0] score_bin;
    logic [NUM_CH-1:0]             winner;
    logic                          game_over;

    modport master (
        output enable, clear, ir_sensor,
        input  hit_pulse, score_bcd, score_bin, winner, game_over
    );

    modport slave (
        input  enable, clear, ir_sensor,
        output hit_pulse, score_bcd, score_bin, winner, game_over
    );
endinterface

// File: rtl/ir_score_tracker_debounce.sv
// ----------------------------------------------------------------------------
// ir_debounce
// Debounces one IR sensor channel:
//   1. a two-flop synchroniser,
//   2. a stable-time filter: the filtered level follows the synchronised
//      input only after DEBOUNCE_CYC consecutive cycles of disagreement,
//   3. a rising-edge detector on the filtered level.
// Ports:
//   clk_100MHz  system clock
//   reset       synchronous, active-high reset
//   sensor      raw asynchronous sensor input
//   rise        high for one cycle after the filtered level goes 0 -> 1
// ----------------------------------------------------------------------------
module ir_debounce #(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic sensor,
    output logic rise
);
    localparam int               CNT_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             s1;
    logic             s2;
    logic             filt;
    logic             filt_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep s1 -> s2 as two real flop stages.
            // Blocking assignments would collapse them into one stage.
            s1     <= sensor;
            s2     <= s1;
            filt_q <= filt;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = filt & ~filt_q;

endmodule

// File: rtl/ir_score_tracker.sv
// ----------------------------------------------------------------------------
// ir_score_tracker
// Multi-channel IR goal/score tracker. It contains one ir_debounce per channel
// and keeps a two-digit BCD score per channel, with a binary copy of the same
// score. With IR_SCORE_WIN_EN defined it also detects a winner.
// Ports:
//   clk_100MHz  system clock, 100 MHz
//   reset       synchronous, active-high reset; takes priority over clear
//   bus         ir_score_tracker_if.slave (enable, clear, ir_sensor in;
//               hit_pulse, score_bcd, score_bin, winner, game_over out)
// Configuration macro IR_SCORE_WIN_EN:
//   defined   A hit that brings a channel to WIN_SCORE sets that channel's
//             winner bit and sets game_over. game_over then freezes all
//             scores until clear or reset.
//   undefined winner and game_over are tied to 0. Scores wrap 99 -> 00.
// ----------------------------------------------------------------------------
module ir_score_tracker
    import ir_score_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int WIN_SCORE    = 11
) (
    input logic                clk_100MHz,
    input logic                reset,
    ir_score_tracker_if.slave  bus
);
    logic [NUM_CH-1:0]             rise;
    logic [NUM_CH-1:0]             hit;
    logic [NUM_CH-1:0]             hit_q;
    logic [NUM_CH-1:0]             winner_q;
    logic                          game_over_q;
    bcd_score_t                    score_q [NUM_CH];
    logic [SCORE_BIN_W-1:0]        bin_q   [NUM_CH];
    logic [8*NUM_CH-1:0]           bcd_flat;
    logic [SCORE_BIN_W*NUM_CH-1:0] bin_flat;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ir_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .sensor     (bus.ir_sensor[g]),
            .rise       (rise[g])
        );
    end

    // A rise that arrives while enable is low, or after game over, is consumed
    // here. It is never counted later.
    assign hit = rise & {NUM_CH{bus.enable & ~game_over_q}};

    // Reset and clear have the same effect on the score state. The debounce
    // state sits in the submodules and only reset reaches it.
    always_ff @(posedge clk_100MHz) begin
        if (reset || bus.clear) begin
            hit_q <= '0;
            // NOTE: the score array is a handful of flops, not a RAM, so every entry is reset explicitly.
            for (int i = 0; i < NUM_CH; i++) begin
                score_q[i] <= '0;
                bin_q[i]   <= '0;
            end
        end else begin
            hit_q <= hit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    score_q[i] <= bcd_inc(score_q[i]);
                    bin_q[i]   <= bin_inc(bin_q[i]);
                end
            end
        end
    end

`ifdef IR_SCORE_WIN_EN
    localparam logic [SCORE_BIN_W-1:0] WIN_BIN = SCORE_BIN_W'(WIN_SCORE);

    // Sets on the edge where a hit makes the score equal WIN_SCORE.
    // Several channels can win on the same edge.
    always_ff @(posedge clk_100MHz) begin
        if (reset || bus.clear) begin
            winner_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i] && (bin_inc(bin_q[i]) == WIN_BIN)) begin
                    winner_q[i] <= 1'b1;
                end
            end
        end
    end

    assign game_over_q = |winner_q;
`else
    logic unused_win_score;

    assign unused_win_score = (WIN_SCORE != 0);
    assign winner_q         = '0;
    assign game_over_q      = 1'b0;
`endif

    // Packs the per-channel scores into the flat bus vectors; channel 0 goes in the low bits.
    always_comb begin
        // NOTE: default assignment first so no bit is left unassigned on any path (no latch).
        bcd_flat = '0;
        bin_flat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            bcd_flat[8*i +: 8]                     = score_q[i];
            bin_flat[SCORE_BIN_W*i +: SCORE_BIN_W] = bin_q[i];
        end
    end

    assign bus.hit_pulse = hit_q;
    assign bus.score_bcd = bcd_flat;
    assign bus.score_bin = bin_flat;
    assign bus.winner    = winner_q;
    assign bus.game_over = game_over_q;

endmodule
